// File: rtl/bit_pattern_pkg.sv
// Shared types and sizing helpers for the bit pattern generator (ones-count to right-justified pattern).
// Build option BIT_PATTERN_CLAMP_EN is consumed by bit_pattern_datapath.
package bit_pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } bp_state_t;

  localparam int BP_DEFAULT_A_WIDTH   = 8;
  localparam int BP_DEFAULT_CNT_WIDTH = 4;

  // Smallest count width able to express every ones-count 0..a_width.
  function automatic int bp_min_cnt_width(input int a_width);
    return $clog2(a_width + 1);
  endfunction

  localparam int BP_MIN_CNT_WIDTH = bp_min_cnt_width(BP_DEFAULT_A_WIDTH);

endpackage

// File: rtl/bit_pattern_datapath.sv
// Count and pattern registers: load clears the pattern, shift appends a one per cycle until the count hits zero.
// BIT_PATTERN_CLAMP_EN: clamp the loaded count to A_WIDTH so latency is bounded.
module bit_pattern_datapath
  import bit_pattern_pkg::*;
#(
  parameter int A_WIDTH   = BP_DEFAULT_A_WIDTH,
  parameter int CNT_WIDTH = BP_DEFAULT_CNT_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [CNT_WIDTH-1:0] i_count,
  output logic [A_WIDTH-1:0]   o_pattern,
  output logic                 o_cnt_zero
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [A_WIDTH-1:0]   r_pattern;
  logic [CNT_WIDTH-1:0] w_load_cnt;

`ifdef BIT_PATTERN_CLAMP_EN
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = CNT_WIDTH'(A_WIDTH);
  assign w_load_cnt = (i_count > LP_CNT_MAX) ? LP_CNT_MAX : i_count;
`else
  assign w_load_cnt = i_count;
`endif

  assign o_cnt_zero = (r_cnt == '0);
  assign o_pattern  = r_pattern;

  // Ones beyond A_WIDTH fall off the MSB, so the word saturates at all-ones.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_pattern <= '0;
    end else if (i_load) begin
      r_cnt     <= w_load_cnt;
      r_pattern <= '0;
    end else if (i_shift && !o_cnt_zero) begin
      r_cnt     <= r_cnt - 1'b1;
      r_pattern <= {r_pattern[A_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/bit_pattern_generator.sv
// Top: start/done controller around the pattern datapath; done/busy are registered state decodes.
// BIT_PATTERN_CLAMP_EN (see datapath) bounds latency to A_WIDTH+2 edges.
module bit_pattern_generator
  import bit_pattern_pkg::*;
#(
  parameter int A_WIDTH   = BP_DEFAULT_A_WIDTH,
  parameter int CNT_WIDTH = BP_DEFAULT_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s,
  input  logic [CNT_WIDTH-1:0] count,
  output logic [A_WIDTH-1:0]   pattern,
  output logic                 done,
  output logic                 busy
);

  bp_state_t r_state;
  logic      r_done;
  logic      r_busy;
  logic      w_load;
  logic      w_shift;
  logic      w_cnt_zero;

  // The count is only captured while idle with start low, so the start edge itself never reloads.
  assign w_load  = (r_state == S_IDLE) && !s;
  assign w_shift = (r_state == S_SHIFT);

  bit_pattern_datapath #(
    .A_WIDTH   (A_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_datapath (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_count    (count),
    .o_pattern  (pattern),
    .o_cnt_zero (w_cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (s) begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_cnt_zero) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
          if (!s) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Directed bench for bit_pattern_generator (A_WIDTH=8, CNT_WIDTH=4); honours BIT_PATTERN_CLAMP_EN.
module tb_bit_pattern_generator;

  logic       clock;
  logic       reset;
  logic       s;
  logic [3:0] count;
  logic [7:0] pattern;
  logic       done;
  logic       busy;

  int checks;
  int failures;

  bit_pattern_generator #(
    .A_WIDTH   (8),
    .CNT_WIDTH (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .s       (s),
    .count   (count),
    .pattern (pattern),
    .done    (done),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Raise s and count edges until done; lat=-1 if it never arrives.
  task automatic raise_and_wait(output int lat, output logic [7:0] pat);
    lat = -1;
    s = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    pat = pattern;
  endtask

  // Two idle edges with s low: the first may leave S_DONE, the second loads count.
  task automatic load_count(input logic [3:0] n);
    s = 1'b0;
    count = n;
    step();
    step();
  endtask

  task automatic test_reset();
    int lat;
    logic [7:0] pat;
    s = 1'b1;
    count = 4'd5;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (pattern !== 8'h00) begin failures++; $display("FAIL reset_pattern got=%h exp=00", pattern); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    raise_and_wait(lat, pat);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL reset_release_latency got=%0d exp=2", lat); end
    checks++;
    if (pat !== 8'h00) begin failures++; $display("FAIL reset_release_pattern got=%h exp=00", pat); end
    s = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    int lat;
    logic [7:0] pat;
    load_count(4'd3);
    raise_and_wait(lat, pat);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL nominal_latency got=%0d exp=5", lat); end
    checks++;
    if (pat !== 8'b0000_0111) begin failures++; $display("FAIL nominal_pattern got=%h exp=07", pat); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL nominal_busy_in_done got=%b exp=0", busy); end
    step();
    step();
    checks++;
    if (done !== 1'b1 || pattern !== 8'h07) begin
      failures++; $display("FAIL nominal_done_hold got done=%b pat=%h exp done=1 pat=07", done, pattern);
    end
    s = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL nominal_return_idle got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_boundaries();
    int lat;
    logic [7:0] pat;
    load_count(4'd0);
    raise_and_wait(lat, pat);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    checks++;
    if (pat !== 8'h00) begin failures++; $display("FAIL zero_pattern got=%h exp=00", pat); end
    load_count(4'd8);
    raise_and_wait(lat, pat);
    checks++;
    if (lat != 10) begin failures++; $display("FAIL full_latency got=%0d exp=10", lat); end
    checks++;
    if (pat !== 8'hFF) begin failures++; $display("FAIL full_pattern got=%h exp=FF", pat); end
  endtask

  task automatic test_over_range();
    int lat;
    int exp_lat;
    logic [7:0] pat;
`ifdef BIT_PATTERN_CLAMP_EN
    exp_lat = 10;
`else
    exp_lat = 14;
`endif
    load_count(4'd12);
    raise_and_wait(lat, pat);
    checks++;
    if (lat != exp_lat) begin failures++; $display("FAIL over_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++;
    if (pat !== 8'hFF) begin failures++; $display("FAIL over_pattern got=%h exp=FF", pat); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [7:0] pat;
    load_count(4'd6);
    s = 1'b1;
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b1 || pattern !== 8'h03) begin
      failures++; $display("FAIL midop_progress got busy=%b pat=%h exp busy=1 pat=03", busy, pattern);
    end
    reset = 1'b1;
    step();
    checks++;
    if (pattern !== 8'h00) begin failures++; $display("FAIL midop_reset_pattern got=%h exp=00", pattern); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midop_reset_flags got busy=%b done=%b exp 0/0", busy, done);
    end
    reset = 1'b0;
    load_count(4'd2);
    raise_and_wait(lat, pat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL midop_rerun_latency got=%0d exp=4", lat); end
    checks++;
    if (pat !== 8'h03) begin failures++; $display("FAIL midop_rerun_pattern got=%h exp=03", pat); end
  endtask

  task automatic test_early_drop();
    int lat;
    load_count(4'd4);
    s = 1'b1;
    step();
    step();
    s = 1'b0;
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      step();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 6) begin failures++; $display("FAIL early_latency got=%0d exp=6", lat); end
    checks++;
    if (pattern !== 8'h0F) begin failures++; $display("FAIL early_pattern got=%h exp=0F", pattern); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL early_done_pulse got done=%b busy=%b exp 0/0", done, busy);
    end
    step();
    checks++;
    if (pattern !== 8'h00) begin failures++; $display("FAIL early_idle_clear got=%h exp=00", pattern); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    s        = 1'b0;
    count    = 4'd0;
    #2;
    test_reset();
    test_nominal();
    test_boundaries();
    test_over_range();
    test_reset_mid_op();
    test_early_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
